shift_seq_ctrl: RTL and testbench

- Sequencing controller for the one-bit-per-cycle serial shifter datapath.
- Accepts an operand, a shift amount, a direction and a logical/arithmetic select through a valid/ready handshake.
- Shifts the held value one position per clock until the amount is exhausted, then presents the result through a second valid/ready handshake.
- Replaces free-running, clock-counted shifting with a bounded, handshaked multi-bit shift for the ALU top level.

---
 rtl/shift_seq_ctrl.sv | 74 +++++++
 tb/tb_shift_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: handshaked controller for a one-bit-per-cycle serial shifter.
// Accepts an operand and amount, shifts once per clock, then holds the result until consumed.
module shift_seq_ctrl #(
    parameter int N  = 4,
    parameter int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [AW-1:0] in_amt,
    input  logic          in_dir,
    input  logic          in_al,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_y,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [AW-1:0] NMAX = AW'(N);
    state_t        state_q, state_d;
    logic [N-1:0]  work_q, work_d, y_q, y_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d, al_q, al_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            al_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            al_q    <= al_d;
        end
    end
    // y_q is separate from work_q so the last result survives while the next operand shifts
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        al_d    = al_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = SHIFT;
                work_d  = in_a;
                dir_d   = in_dir;
                al_d    = in_al;
                cnt_d   = (in_amt >= NMAX) ? NMAX : in_amt;
            end
            SHIFT: if (cnt_q == '0) begin
                state_d = DONE;
                y_d     = work_q;
            end else begin
                cnt_d  = cnt_q - AW'(1);
                work_d = dir_q ? {al_q & work_q[N-1], work_q[N-1:1]} : {work_q[N-2:0], 1'b0};
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_y     = y_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: vector table, corner sequences and random ops against an arithmetic shift model.
module tb_shift_seq_ctrl;
    localparam int N = 8;
    localparam int AW = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, in_dir = 1'b0, in_al = 1'b0;
    logic out_valid, out_ready = 1'b0, busy;
    logic [N-1:0] in_a = '0, out_y;
    logic [AW-1:0] in_amt = '0;
    int n_chk = 0, n_fail = 0;

    shift_seq_ctrl #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_amt(in_amt), .in_dir(in_dir), .in_al(in_al), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] amt;
        logic       dir;
        logic       al;
        logic [7:0] y;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input int amt, input logic dir, input logic al);
        int k, s;
        k = (amt >= N) ? N : amt;
        if (!dir) return 8'((int'(a) << k) & 255);
        if (!al) return 8'(int'(a) >> k);
        s = a[7] ? int'(a) - 256 : int'(a);
        return 8'((s >>> k) & 255);
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [3:0] amt, input logic dir, input logic al,
                         input logic [7:0] exp, input int hold);
        int lat, n, k;
        k = (amt >= N) ? N : int'(amt);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", in_ready, 1);
        in_valid = 1'b1; in_a = a; in_amt = amt; in_dir = dir; in_al = al;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 8'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom); in_al = 1'($urandom);
        check("busy_after_accept", {in_ready, busy}, 2'b01);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, k + 1);
        check("result", out_y, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_hold", {out_valid, in_ready, busy, out_y}, {3'b101, exp});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("after_handshake", {out_valid, in_ready, busy, out_y}, {3'b010, exp});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[10];
        logic [7:0] res[$];
        logic [7:0] ra;
        logic [3:0] ramt;
        logic rdir, ral;
        int n, seen, both;
        vt[0] = '{8'h96, 4'd3,  1'b0, 1'b0, 8'hB0};
        vt[1] = '{8'h96, 4'd3,  1'b1, 1'b0, 8'h12};
        vt[2] = '{8'h96, 4'd3,  1'b1, 1'b1, 8'hF2};
        vt[3] = '{8'h5A, 4'd0,  1'b1, 1'b0, 8'h5A};
        vt[4] = '{8'h96, 4'd12, 1'b0, 1'b0, 8'h00};
        vt[5] = '{8'h96, 4'd12, 1'b1, 1'b1, 8'hFF};
        vt[6] = '{8'h96, 4'd5,  1'b0, 1'b1, 8'hC0};
        vt[7] = '{8'h7F, 4'd8,  1'b1, 1'b1, 8'h00};
        vt[8] = '{8'h80, 4'd7,  1'b1, 1'b0, 8'h01};
        vt[9] = '{8'h5A, 4'd15, 1'b1, 1'b0, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {in_ready, out_valid, busy, out_y}, {3'b100, 8'h00});

        foreach (vt[i]) do_op(vt[i].a, vt[i].amt, vt[i].dir, vt[i].al, vt[i].y, 0);

        do_op(8'h96, 4'd2, 1'b1, 1'b1, 8'hE5, 5);

        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hFF; in_amt = 4'd7; in_dir = 1'b0; in_al = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        check("reset_mid_shift", {in_ready, out_valid, busy, out_y}, {3'b100, 8'h00});
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_result_after_reset", seen, 0);

        in_valid = 1'b1; in_a = 8'h01; in_amt = 4'd1; in_dir = 1'b0; in_al = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 8'h80; in_amt = 4'd7; in_dir = 1'b1; in_al = 1'b0;
        check("b2b_first_accepted", in_ready, 0);
        n = 0; both = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            if (out_valid) res.push_back(out_y);
            if (out_valid && in_ready) both++;
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = 8'hFF; in_dir = 1'b0;
        n = 0;
        while (n < 40) begin
            if (out_valid) begin
                res.push_back(out_y);
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_count", res.size(), 2);
        check("b2b_first", (res.size() > 0) ? res[0] : 8'hxx, 8'h02);
        check("b2b_second", (res.size() > 1) ? res[1] : 8'hxx, 8'h01);
        check("b2b_no_overlap", both, 0);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom); ramt = 4'($urandom); rdir = 1'($urandom); ral = 1'($urandom);
            do_op(ra, ramt, rdir, ral, ref_shift(ra, int'(ramt), rdir, ral), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
